// File: rtl/alu_control_seq.sv
// Sequenced ALU control: accepts one operation per handshake, holds alucontrol
// through a 1- or MUL_CYCLES-cycle EXEC phase and owns the NZCV flag register.
module alu_control_seq #(
  parameter int unsigned ALUCTRL_W  = 3,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic                 aluop,
  input  logic [4:0]           funct,
  input  logic                 is_mul,
  input  logic [3:0]           cond,
  input  logic [3:0]           alu_flags,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 done,
  output logic                 regwrite,
  output logic [3:0]           flags,
  output logic                 cond_pass,
  output logic                 illegal
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] flagw_q;
  logic       wb_q;
  logic       illegal_q;

  logic [3:0] cmd;
  logic       s_bit;
  logic [2:0] dec_ctrl;
  logic [1:0] dec_flagw;
  logic       dec_wb;
  logic       dec_ill;
  logic       dec_cp;
  logic [3:0] lat_cnt;
  logic       n_f, z_f, c_f, v_f;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  // Decode priority: address add (aluop=0) > multiply > data-processing cmd.
  always_comb begin
    dec_ctrl  = '0;
    dec_flagw = '0;
    dec_wb    = 1'b0;
    dec_ill   = 1'b0;
    if (!aluop) begin
      dec_ctrl = '0;
    end else if (is_mul) begin
      dec_ctrl  = 3'd6;
      dec_flagw = {s_bit, 1'b0};
      dec_wb    = 1'b1;
    end else begin
      case (cmd)
        4'b0100: begin dec_ctrl = 3'd0; dec_flagw = {s_bit, s_bit}; dec_wb = 1'b1; end
        4'b0010: begin dec_ctrl = 3'd1; dec_flagw = {s_bit, s_bit}; dec_wb = 1'b1; end
        4'b0000: begin dec_ctrl = 3'd2; dec_flagw = {s_bit, 1'b0};  dec_wb = 1'b1; end
        4'b1100: begin dec_ctrl = 3'd3; dec_flagw = {s_bit, 1'b0};  dec_wb = 1'b1; end
        4'b0001: begin dec_ctrl = 3'd4; dec_flagw = {s_bit, 1'b0};  dec_wb = 1'b1; end
        4'b1101: begin dec_ctrl = 3'd5; dec_flagw = {s_bit, 1'b0};  dec_wb = 1'b1; end
        4'b1010: begin dec_ctrl = 3'd1; dec_flagw = 2'b11;          dec_wb = 1'b0; end
        default: begin dec_ctrl = 3'd0; dec_flagw = 2'b00;          dec_ill = 1'b1; end
      endcase
    end
  end

  assign n_f = flags[3];
  assign z_f = flags[2];
  assign c_f = flags[1];
  assign v_f = flags[0];

  always_comb begin
    dec_cp = 1'b1;
    case (cond)
      4'b0000: dec_cp = z_f;
      4'b0001: dec_cp = !z_f;
      4'b0010: dec_cp = c_f;
      4'b0011: dec_cp = !c_f;
      4'b0100: dec_cp = n_f;
      4'b0101: dec_cp = !n_f;
      4'b0110: dec_cp = v_f;
      4'b0111: dec_cp = !v_f;
      4'b1000: dec_cp = c_f && !z_f;
      4'b1001: dec_cp = !c_f || z_f;
      4'b1010: dec_cp = (n_f == v_f);
      4'b1011: dec_cp = (n_f != v_f);
      4'b1100: dec_cp = !z_f && (n_f == v_f);
      4'b1101: dec_cp = z_f || (n_f != v_f);
      default: dec_cp = 1'b1;
    endcase
  end

  assign lat_cnt = is_mul ? 4'(MUL_CYCLES - 1) : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alucontrol <= '0;
      flags      <= '0;
      cond_pass  <= 1'b0;
      flagw_q    <= '0;
      wb_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (op_valid) begin
        state      <= EXEC;
        cnt        <= lat_cnt;
        alucontrol <= ALUCTRL_W'(dec_ctrl);
        cond_pass  <= dec_cp;
        flagw_q    <= dec_flagw;
        wb_q       <= dec_wb;
        illegal_q  <= dec_ill;
      end
    end else begin
      if (cnt == 4'd0) begin
        state <= IDLE;
        if (flagw_q[1] && cond_pass) flags[3:2] <= alu_flags[3:2];
        if (flagw_q[0] && cond_pass) flags[1:0] <= alu_flags[1:0];
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign op_ready = (state == IDLE);
  assign done     = (state == EXEC) && (cnt == 4'd0);
  assign regwrite = done && wb_q && cond_pass;
  assign illegal  = done && illegal_q;

endmodule
